// File: rtl/ps2_kbd_if.sv
// Keyboard controller bus: FIFO pop handshake toward the byte FIFO plus key/display outputs.
interface ps2_kbd_if #(
  parameter int CNT_WIDTH = 8
) ();
  logic                 fifo_empty;
  logic [7:0]           fifo_data;
  logic                 fifo_rd_en;
  logic                 key_down;
  logic                 key_ext;
  logic [7:0]           key_code;
  logic [7:0]           key_ascii;
  logic [CNT_WIDTH-1:0] press_cnt;
  logic [7:0]           seg0, seg1, seg2, seg3, seg4, seg5;

  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd_en, key_down, key_ext, key_code, key_ascii, press_cnt,
    output seg0, seg1, seg2, seg3, seg4, seg5
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd_en, key_down, key_ext, key_code, key_ascii, press_cnt,
    input  seg0, seg1, seg2, seg3, seg4, seg5
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// Set-2 scan-code parser: pops FIFO bytes, tracks the held key, counts presses,
// maps codes to ASCII and drives six hex 7-segment digits.
module ps2_kbd_ctrl #(
  parameter int CNT_WIDTH      = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  ps2_kbd_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BRK     = 2'd1;
  localparam logic [1:0] S_EXT     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;
  localparam logic [7:0] BLANK     = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [1:0]           r_state;
  logic                 r_down;
  logic                 r_ext;
  logic [7:0]           r_code;
  logic [7:0]           r_ascii;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_rd;
  logic                 w_ext_ctx;
  logic                 w_brk_ctx;
  logic                 w_match;
  logic [CNT_WIDTH+7:0] w_cnt_ext;
  logic [7:0]           w_cnt8;

  function automatic logic [7:0] to_ascii(input logic [7:0] b);
    case (b)
      8'h1C: to_ascii = 8'h41; 8'h32: to_ascii = 8'h42; 8'h21: to_ascii = 8'h43;
      8'h23: to_ascii = 8'h44; 8'h24: to_ascii = 8'h45; 8'h2B: to_ascii = 8'h46;
      8'h34: to_ascii = 8'h47; 8'h33: to_ascii = 8'h48; 8'h43: to_ascii = 8'h49;
      8'h3B: to_ascii = 8'h4A; 8'h42: to_ascii = 8'h4B; 8'h4B: to_ascii = 8'h4C;
      8'h3A: to_ascii = 8'h4D; 8'h31: to_ascii = 8'h4E; 8'h44: to_ascii = 8'h4F;
      8'h4D: to_ascii = 8'h50; 8'h15: to_ascii = 8'h51; 8'h2D: to_ascii = 8'h52;
      8'h1B: to_ascii = 8'h53; 8'h2C: to_ascii = 8'h54; 8'h3C: to_ascii = 8'h55;
      8'h2A: to_ascii = 8'h56; 8'h1D: to_ascii = 8'h57; 8'h22: to_ascii = 8'h58;
      8'h35: to_ascii = 8'h59; 8'h1A: to_ascii = 8'h5A;
      8'h45: to_ascii = 8'h30; 8'h16: to_ascii = 8'h31; 8'h1E: to_ascii = 8'h32;
      8'h26: to_ascii = 8'h33; 8'h25: to_ascii = 8'h34; 8'h2E: to_ascii = 8'h35;
      8'h36: to_ascii = 8'h36; 8'h3D: to_ascii = 8'h37; 8'h3E: to_ascii = 8'h38;
      8'h46: to_ascii = 8'h39;
      default: to_ascii = 8'h00;
    endcase
  endfunction

  // Glyph table is stored active-low; inverted for active-high panels.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0; 4'h1: g = 8'hF9; 4'h2: g = 8'hA4; 4'h3: g = 8'hB0;
      4'h4: g = 8'h99; 4'h5: g = 8'h92; 4'h6: g = 8'h82; 4'h7: g = 8'hF8;
      4'h8: g = 8'h80; 4'h9: g = 8'h90; 4'hA: g = 8'h88; 4'hB: g = 8'h83;
      4'hC: g = 8'hC6; 4'hD: g = 8'hA1; 4'hE: g = 8'h86; default: g = 8'h8E;
    endcase
    glyph = SEG_ACTIVE_LOW ? g : ~g;
  endfunction

  assign w_rd      = ~bus.fifo_empty & ~i_rst;
  assign w_ext_ctx = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_brk_ctx = (r_state == S_BRK) || (r_state == S_EXT_BRK);
  assign w_match   = r_down && (r_code == bus.fifo_data) && (r_ext == w_ext_ctx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_down  <= 1'b0;
      r_ext   <= 1'b0;
      r_code  <= 8'h00;
      r_ascii <= 8'h00;
      r_cnt   <= '0;
    end else if (w_rd) begin
      case (bus.fifo_data)
        8'hF0:   r_state <= w_ext_ctx ? S_EXT_BRK : S_BRK;
        8'hE0:   r_state <= S_EXT;
        default: begin
          r_state <= S_IDLE;
          if (w_brk_ctx) begin
            // A break for anything other than the held key is stale and ignored.
            if (w_match) r_down <= 1'b0;
          end else if (!w_match) begin
            r_code  <= bus.fifo_data;
            r_ext   <= w_ext_ctx;
            r_down  <= 1'b1;
            r_ascii <= w_ext_ctx ? 8'h00 : to_ascii(bus.fifo_data);
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign w_cnt_ext = {8'h00, r_cnt};
  assign w_cnt8    = w_cnt_ext[7:0];

  assign bus.fifo_rd_en = w_rd;
  assign bus.key_down   = r_down;
  assign bus.key_ext    = r_ext;
  assign bus.key_code   = r_code;
  assign bus.key_ascii  = r_ascii;
  assign bus.press_cnt  = r_cnt;
  assign bus.seg0       = r_down ? glyph(r_code[3:0])  : BLANK;
  assign bus.seg1       = r_down ? glyph(r_code[7:4])  : BLANK;
  assign bus.seg2       = r_down ? glyph(r_ascii[3:0]) : BLANK;
  assign bus.seg3       = r_down ? glyph(r_ascii[7:4]) : BLANK;
  assign bus.seg4       = glyph(w_cnt8[3:0]);
  assign bus.seg5       = glyph(w_cnt8[7:4]);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: default instance plus an active-high, 4-bit-counter variant.
module tb_ps2_kbd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ps2_kbd_if #(.CNT_WIDTH(8)) ifc ();
  ps2_kbd_if #(.CNT_WIDTH(4)) ifc2 ();

  assign ifc2.fifo_empty = ifc.fifo_empty;
  assign ifc2.fifo_data  = ifc.fifo_data;

  ps2_kbd_ctrl #(.CNT_WIDTH(8), .SEG_ACTIVE_LOW(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .bus(ifc.master));

  ps2_kbd_ctrl #(.CNT_WIDTH(4), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .i_clk(clk), .i_rst(rst), .bus(ifc2.master));

  // {key_down, key_ext, key_code, key_ascii, press_cnt}
  function automatic logic [25:0] st();
    return {ifc.key_down, ifc.key_ext, ifc.key_code, ifc.key_ascii, ifc.press_cnt};
  endfunction

  // {seg5, seg4, seg3, seg2, seg1, seg0}
  function automatic logic [47:0] segs();
    return {ifc.seg5, ifc.seg4, ifc.seg3, ifc.seg2, ifc.seg1, ifc.seg0};
  endfunction

  task automatic push(input logic [7:0] b);
    ifc.fifo_data  = b;
    ifc.fifo_empty = 1'b0;
    @(posedge clk);
    #1;
    ifc.fifo_empty = 1'b1;
  endtask

  task automatic do_reset();
    ifc.fifo_empty = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.fifo_empty = 1'b0;
    ifc.fifo_data  = 8'h1C;
    @(posedge clk);
    #1;
    n_tests++;
    if (ifc.fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL rd_en_in_reset: got %b want 0", ifc.fifo_rd_en);
    end
    ifc.fifo_empty = 1'b1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (ifc.fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL rd_en_empty: got %b want 0", ifc.fifo_rd_en);
    end
    n_tests++;
    if (st() !== 26'h0) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", st(), 26'h0);
    end
    n_tests++;
    if (segs() !== 48'hC0C0_FFFF_FFFF) begin
      n_fail++; $display("FAIL reset_segs: got %h want %h", segs(), 48'hC0C0_FFFF_FFFF);
    end
    n_tests++;
    if ({ifc2.seg4, ifc2.seg0} !== 16'h3F00) begin
      n_fail++; $display("FAIL reset_segs_hi: got %h want %h", {ifc2.seg4, ifc2.seg0}, 16'h3F00);
    end
  endtask

  task automatic test_make_break();
    do_reset();
    push(8'h1C);
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01}) begin
      n_fail++; $display("FAIL make_1C: got %h want %h", st(), {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01});
    end
    n_tests++;
    if (segs() !== 48'hC0F9_99F9_F9C6) begin
      n_fail++; $display("FAIL make_1C_segs: got %h want %h", segs(), 48'hC0F9_99F9_F9C6);
    end
    n_tests++;
    if (ifc2.seg0 !== 8'h39) begin
      n_fail++; $display("FAIL make_1C_seg0_hi: got %h want 39", ifc2.seg0);
    end
    push(8'hF0);
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01}) begin
      n_fail++; $display("FAIL after_F0: got %h want %h", st(), {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01});
    end
    push(8'h1C);
    n_tests++;
    if (st() !== {1'b0, 1'b0, 8'h1C, 8'h41, 8'h01}) begin
      n_fail++; $display("FAIL break_1C: got %h want %h", st(), {1'b0, 1'b0, 8'h1C, 8'h41, 8'h01});
    end
    n_tests++;
    if (segs() !== 48'hC0F9_FFFF_FFFF) begin
      n_fail++; $display("FAIL break_1C_segs: got %h want %h", segs(), 48'hC0F9_FFFF_FFFF);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(8'h1C);
      n_tests++;
      if (st() !== {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01}) begin
        n_fail++; $display("FAIL typematic_%0d: got %h want %h", i, st(), {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01});
      end
    end
    push(8'hF0);
    push(8'h1C);
    n_tests++;
    if (st() !== {1'b0, 1'b0, 8'h1C, 8'h41, 8'h01}) begin
      n_fail++; $display("FAIL typematic_release: got %h want %h", st(), {1'b0, 1'b0, 8'h1C, 8'h41, 8'h01});
    end
  endtask

  task automatic test_extended();
    do_reset();
    push(8'hE0);
    n_tests++;
    if (st() !== 26'h0) begin
      n_fail++; $display("FAIL ext_prefix_only: got %h want %h", st(), 26'h0);
    end
    push(8'h75);
    n_tests++;
    if (st() !== {1'b1, 1'b1, 8'h75, 8'h00, 8'h01}) begin
      n_fail++; $display("FAIL ext_make: got %h want %h", st(), {1'b1, 1'b1, 8'h75, 8'h00, 8'h01});
    end
    n_tests++;
    if (segs() !== 48'hC0F9_C0C0_F892) begin
      n_fail++; $display("FAIL ext_make_segs: got %h want %h", segs(), 48'hC0F9_C0C0_F892);
    end
    push(8'hE0); push(8'hF0); push(8'h75);
    n_tests++;
    if (st() !== {1'b0, 1'b1, 8'h75, 8'h00, 8'h01}) begin
      n_fail++; $display("FAIL ext_break: got %h want %h", st(), {1'b0, 1'b1, 8'h75, 8'h00, 8'h01});
    end
    push(8'hE0); push(8'h75);
    push(8'h75);
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h75, 8'h00, 8'h03}) begin
      n_fail++; $display("FAIL plain_after_ext: got %h want %h", st(), {1'b1, 1'b0, 8'h75, 8'h00, 8'h03});
    end
    push(8'hE0); push(8'hF0); push(8'h75);
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h75, 8'h00, 8'h03}) begin
      n_fail++; $display("FAIL stale_ext_break: got %h want %h", st(), {1'b1, 1'b0, 8'h75, 8'h00, 8'h03});
    end
    push(8'hF0); push(8'h75);
    n_tests++;
    if (st() !== {1'b0, 1'b0, 8'h75, 8'h00, 8'h03}) begin
      n_fail++; $display("FAIL plain_break: got %h want %h", st(), {1'b0, 1'b0, 8'h75, 8'h00, 8'h03});
    end
  endtask

  task automatic test_overlap();
    do_reset();
    push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h32, 8'h42, 8'h02}) begin
      n_fail++; $display("FAIL overlap_hold: got %h want %h", st(), {1'b1, 1'b0, 8'h32, 8'h42, 8'h02});
    end
    push(8'hF0); push(8'h32);
    n_tests++;
    if (st() !== {1'b0, 1'b0, 8'h32, 8'h42, 8'h02}) begin
      n_fail++; $display("FAIL overlap_release: got %h want %h", st(), {1'b0, 1'b0, 8'h32, 8'h42, 8'h02});
    end
  endtask

  task automatic test_ascii();
    logic [7:0] codes [6] = '{8'h16, 8'h45, 8'h1A, 8'h15, 8'h46, 8'h5A};
    logic [7:0] ascs  [6] = '{8'h31, 8'h30, 8'h5A, 8'h51, 8'h39, 8'h00};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(codes[i]);
      n_tests++;
      if (st() !== {1'b1, 1'b0, codes[i], ascs[i], 8'(i + 1)}) begin
        n_fail++; $display("FAIL ascii_%h: got %h want %h", codes[i], st(), {1'b1, 1'b0, codes[i], ascs[i], 8'(i + 1)});
      end
      push(8'hF0); push(codes[i]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ifc.fifo_empty = 1'b0;
    foreach (ifc.fifo_data[k]) ; // no-op keeps loop variable scope local
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: ifc.fifo_data = 8'h1C;
        1: ifc.fifo_data = 8'h32;
        2: ifc.fifo_data = 8'h21;
        default: ifc.fifo_data = 8'h23;
      endcase
      @(posedge clk);
      #1;
    end
    ifc.fifo_empty = 1'b1;
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h23, 8'h44, 8'h04}) begin
      n_fail++; $display("FAIL b2b_makes: got %h want %h", st(), {1'b1, 1'b0, 8'h23, 8'h44, 8'h04});
    end
    push(8'hF0); push(8'h23); push(8'hE0); push(8'h75);
    n_tests++;
    if (st() !== {1'b1, 1'b1, 8'h75, 8'h00, 8'h05}) begin
      n_fail++; $display("FAIL b2b_mixed: got %h want %h", st(), {1'b1, 1'b1, 8'h75, 8'h00, 8'h05});
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push(8'h1C); push(8'hF0); push(8'h1C);
    end
    n_tests++;
    if (st() !== {1'b0, 1'b0, 8'h1C, 8'h41, 8'h00}) begin
      n_fail++; $display("FAIL wrap_state: got %h want %h", st(), {1'b0, 1'b0, 8'h1C, 8'h41, 8'h00});
    end
    n_tests++;
    if (segs() !== 48'hC0C0_FFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_segs: got %h want %h", segs(), 48'hC0C0_FFFF_FFFF);
    end
    n_tests++;
    if ({ifc2.press_cnt, ifc2.seg5, ifc2.seg4} !== 20'h0_3F3F) begin
      n_fail++; $display("FAIL wrap_hi: got %h want %h", {ifc2.press_cnt, ifc2.seg5, ifc2.seg4}, 20'h0_3F3F);
    end
    push(8'h1C);
    do_reset();
    push(8'h1C);
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01}) begin
      n_fail++; $display("FAIL make_after_reset: got %h want %h", st(), {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01});
    end
    do_reset();
    push(8'hF0);
    rst = 1'b1;
    ifc.fifo_data  = 8'h1C;
    ifc.fifo_empty = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (st() !== 26'h0) begin
      n_fail++; $display("FAIL no_pop_in_reset: got %h want %h", st(), 26'h0);
    end
    @(posedge clk);
    #1;
    ifc.fifo_empty = 1'b1;
    n_tests++;
    if (st() !== {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01}) begin
      n_fail++; $display("FAIL prefix_discard: got %h want %h", st(), {1'b1, 1'b0, 8'h1C, 8'h41, 8'h01});
    end
  endtask

  initial begin
    ifc.fifo_empty = 1'b1;
    ifc.fifo_data  = 8'h00;
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_overlap();
    test_ascii();
    test_back_to_back();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end
endmodule
